// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one byte-wide uart transmitter between N_REQ byte-stream
// requesters. Ownership is handed out round-robin, one packet at a time. A
// grant is held until the owner's last byte has gone out, or until the owner
// has left its valid low for TIMEOUT cycles while it could have sent. After
// every byte the arbiter waits GAP_CYCLES cycles before it accepts another.
// This gives the uart time to raise tx_busy before the next byte is offered.
//
// Optional build macro: UART_ARB_TAG_EN
//   When defined, each granted packet is preceded by a tag byte
//   8'hA0 | requester_index.
//
// Ports:
//   clk_50_mhz     clock, shared with the uart instance
//   rst            synchronous, active-high reset
//   req_valid      per-requester byte valid
//   req_data       per-requester byte; requester i on [8i+7:8i]
//   req_last       final byte of a packet, qualified by req_valid
//   req_ready      combinational byte accept (at most one bit high)
//   grant          one-hot current owner; zero when idle
//   uart_din       byte to the uart
//   uart_wr_en     one-cycle write strobe to the uart
//   uart_tx_busy   uart transmitter busy
//   arb_busy       arbiter is not idle
//   timeout_pulse  one-cycle pulse when a grant is revoked by timeout
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ      = 2,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic               clk_50_mhz,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         uart_din,
  output logic               uart_wr_en,
  input  logic               uart_tx_busy,
  output logic               arb_busy,
  output logic               timeout_pulse
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
`ifdef UART_ARB_TAG_EN
    ST_GAP  = 2'd2,
    ST_TAG  = 2'd3
`else
    ST_GAP  = 2'd2
`endif
  } state_t;

  state_t           state_q,     state_d;
  logic [N_REQ-1:0] grant_q,     grant_d;
  logic [IDX_W-1:0] last_idx_q,  last_idx_d;
  logic             last_flag_q, last_flag_d;
  logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
  logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
  logic [7:0]       din_q,       din_d;
  logic             wr_en_q,     wr_en_d;
  logic             timeout_q,   timeout_d;

  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;
  logic             xfer;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  // Saturating increment for the idle-cycle counter.
  function automatic logic [TO_W-1:0] to_inc(input logic [TO_W-1:0] c);
    return (c == TO_MAX) ? c : c + TO_W'(1);
  endfunction

  // last_idx_q always names the current owner while a grant is held.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (last_idx_q == IDX_W'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  // Round-robin search starting one past the previous owner, with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = LAST_IDX;
    cand       = last_idx_q;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_SEND && !uart_tx_busy) begin
      req_ready = grant_q;
    end
  end

  assign xfer = (state_q == ST_SEND) && !uart_tx_busy && g_valid;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_idx_d  = last_idx_q;
    last_flag_d = last_flag_q;
    gap_cnt_d   = gap_cnt_q;
    to_cnt_d    = to_cnt_q;
    din_d       = din_q;
    wr_en_d     = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          last_idx_d = pick_idx;
          to_cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
          state_d    = ST_TAG;
`else
          state_d    = ST_SEND;
`endif
        end
      end
      ST_SEND: begin
        if (xfer) begin
          din_d       = g_data;
          wr_en_d     = 1'b1;
          last_flag_d = g_last;
          gap_cnt_d   = GAP_LOAD;
          to_cnt_d    = '0;
          state_d     = ST_GAP;
        end else if (!g_valid) begin
          // Only an absent owner counts; a busy uart never starves a grant.
          if (to_cnt_q == TO_MAX) begin
            timeout_d = 1'b1;
            grant_d   = '0;
            to_cnt_d  = '0;
            state_d   = ST_IDLE;
          end else begin
            to_cnt_d = to_inc(to_cnt_q);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          if (last_flag_q) begin
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            to_cnt_d = '0;
            state_d  = ST_SEND;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        if (!uart_tx_busy) begin
          din_d       = 8'hA0 | {{(8-IDX_W){1'b0}}, last_idx_q};
          wr_en_d     = 1'b1;
          last_flag_d = 1'b0;
          gap_cnt_d   = GAP_LOAD;
          state_d     = ST_GAP;
        end
      end
`endif
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50_mhz) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_idx_q  <= LAST_IDX;
      last_flag_q <= 1'b0;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
      din_q       <= '0;
      wr_en_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_idx_q  <= last_idx_d;
      last_flag_q <= last_flag_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
      din_q       <= din_d;
      wr_en_q     <= wr_en_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant         = grant_q;
  assign uart_din      = din_q;
  assign uart_wr_en    = wr_en_q;
  assign timeout_pulse = timeout_q;
  assign arb_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Drives two requesters from byte queues and compares every output on every
// cycle against a timestamp-based reference model. The model tracks who owns
// the uart, the earliest cycle at which that owner may next send, and the
// idle cycles counted since then. Directed scenarios add literal
// expectations on the logged byte stream.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N_REQ      = 2;
  localparam int GAP_CYCLES = 16;
  localparam int TIMEOUT    = 1024;
`ifdef UART_ARB_TAG_EN
  localparam int TAG_EN = 1;
`else
  localparam int TAG_EN = 0;
`endif

  logic               clk_50_mhz = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic [7:0]         uart_din;
  logic               uart_wr_en;
  logic               uart_tx_busy;
  logic               arb_busy;
  logic               timeout_pulse;

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_50_mhz(clk_50_mhz), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .uart_din(uart_din), .uart_wr_en(uart_wr_en), .uart_tx_busy(uart_tx_busy),
    .arb_busy(arb_busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk_50_mhz = ~clk_50_mhz;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Requester byte sources: {last, data}
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit         rnd_mode = 1'b0;

  // Reference model
  int         m_owner, m_last, m_accept, m_idle;
  bit         m_rel, m_tagp, m_wr, m_to;
  logic [7:0] m_din;

  // Logs of observed DUT activity for the directed scenarios
  logic [7:0]       pay_din[$];
  int               pay_cyc[$];
  logic [N_REQ-1:0] pay_gnt[$];
  logic [7:0]       tag_din[$];
  int               to_cyc[$];
  int               busy_fall;
  bit               prev_busy;
  int               ready_while_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int qsize(input int r);
    return (r == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [8:0] qhead(input int r);
    return (r == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int r, input logic [7:0] b, input logic l);
    if (r == 0) q0.push_back({l, b});
    else        q1.push_back({l, b});
  endtask

  task automatic qpop(input int r);
    if (r == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int o);
    logic [N_REQ-1:0] v;
    v = '0;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  function automatic int pc(input int k);
    return (k < pay_cyc.size()) ? pay_cyc[k] : -99999;
  endfunction
  function automatic logic [8:0] pd(input int k);
    return (k < pay_din.size()) ? {1'b0, pay_din[k]} : 9'h1FF;
  endfunction
  function automatic logic [N_REQ-1:0] pg(input int k);
    return (k < pay_gnt.size()) ? pay_gnt[k] : '1;
  endfunction
  function automatic int tc(input int k);
    return (k < to_cyc.size()) ? to_cyc[k] : -99999;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = N_REQ - 1; m_accept = 0; m_idle = 0;
    m_rel = 1'b0; m_tagp = 1'b0; m_wr = 1'b0; m_to = 1'b0; m_din = 8'h00;
  endtask

  task automatic clear_logs();
    pay_din.delete(); pay_cyc.delete(); pay_gnt.delete();
    tag_din.delete(); to_cyc.delete();
    busy_fall = -1; ready_while_busy = 0;
  endtask

  // Advances the model from the current cycle's inputs to the next cycle.
  task automatic model_step();
    m_wr = 1'b0;
    m_to = 1'b0;
    if (rst) begin
      model_reset();
      q0.delete();
      q1.delete();
      return;
    end
    if (m_owner < 0) begin
      for (int k = 1; k <= N_REQ; k++) begin
        int c;
        c = (m_last + k) % N_REQ;
        if (m_owner < 0 && req_valid[c]) begin
          m_owner = c; m_last = c; m_accept = cyc + 1; m_idle = 0;
          m_rel = 1'b0; m_tagp = (TAG_EN != 0);
        end
      end
    end else if (cyc >= m_accept && !m_rel) begin
      if (m_tagp) begin
        if (!uart_tx_busy) begin
          m_wr = 1'b1; m_din = 8'hA0 | 8'(m_owner); m_tagp = 1'b0;
          m_accept = cyc + 1 + GAP_CYCLES;
        end
      end else if (req_valid[m_owner] && !uart_tx_busy) begin
        m_wr = 1'b1; m_din = req_data[8*m_owner +: 8]; m_rel = req_last[m_owner];
        m_accept = cyc + 1 + GAP_CYCLES; m_idle = 0;
        qpop(m_owner);
      end else if (!req_valid[m_owner]) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_to = 1'b1; m_owner = -1; m_idle = 0;
        end
      end
    end
    if (m_owner >= 0 && m_rel && cyc + 1 >= m_accept) begin
      m_owner = -1;
      m_rel   = 1'b0;
    end
  endtask

  task automatic tick();
    logic [N_REQ-1:0] exp_ready;
    for (int r = 0; r < N_REQ; r++) begin
      logic [8:0] h;
      bit v;
      v = (qsize(r) > 0);
      if (rnd_mode && $urandom_range(0, 7) == 0) v = 1'b0;
      h = (qsize(r) > 0) ? qhead(r) : 9'h000;
      req_valid[r]        = v;
      req_data[8*r +: 8]  = h[7:0];
      req_last[r]         = h[8];
    end
    #1;
    exp_ready = '0;
    if (m_owner >= 0 && cyc >= m_accept && !m_rel && !m_tagp && !uart_tx_busy)
      exp_ready[m_owner] = 1'b1;
    chk("grant",         32'(grant),         32'(onehot(m_owner)));
    chk("uart_wr_en",    32'(uart_wr_en),    32'(m_wr));
    chk("uart_din",      32'(uart_din),      32'(m_din));
    chk("arb_busy",      32'(arb_busy),      32'(m_owner >= 0));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_to));
    chk("req_ready",     32'(req_ready),     32'(exp_ready));
    if (uart_wr_en === 1'b1) begin
      if (TAG_EN != 0 && (uart_din == 8'hA0 || uart_din == 8'hA1)) begin
        tag_din.push_back(uart_din);
      end else begin
        pay_din.push_back(uart_din);
        pay_cyc.push_back(cyc);
        pay_gnt.push_back(grant);
      end
    end
    if (timeout_pulse === 1'b1) to_cyc.push_back(cyc);
    if (prev_busy && arb_busy === 1'b0) busy_fall = cyc;
    prev_busy = (arb_busy === 1'b1);
    if (uart_tx_busy && req_ready !== '0) ready_while_busy++;
    model_step();
    @(negedge clk_50_mhz);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int b;
    rst = 1'b1; uart_tx_busy = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    model_reset();
    clear_logs();
    prev_busy = 1'b0;
    repeat (2) @(negedge clk_50_mhz);

    // Single 3-byte packet from requester 0
    do_reset();
    qpush(0, 8'h11, 1'b0); qpush(0, 8'h22, 1'b0); qpush(0, 8'h33, 1'b1);
    repeat (90) tick();
    chk("t1_count", 32'(pay_din.size()), 32'd3);
    chk("t1_b0", 32'(pd(0)), 32'h11);
    chk("t1_b1", 32'(pd(1)), 32'h22);
    chk("t1_b2", 32'(pd(2)), 32'h33);
    chk("t1_space01", 32'(pc(1) - pc(0)), 32'd17);
    chk("t1_space12", 32'(pc(2) - pc(1)), 32'd17);
    chk("t1_grant", 32'({pg(0), pg(1), pg(2)}), 32'b010101);
    chk("t1_busy_fall", 32'(busy_fall - pc(2)), 32'd16);

    // Two 2-byte packets arriving together: no interleaving, req0 first
    do_reset();
    qpush(0, 8'hA5, 1'b0); qpush(0, 8'h5A, 1'b1);
    qpush(1, 8'hC3, 1'b0); qpush(1, 8'h3C, 1'b1);
    repeat (150) tick();
    chk("t2_order", 32'({pd(0)[7:0], pd(1)[7:0], pd(2)[7:0], pd(3)[7:0]}), 32'hA55AC33C);

    // Continuous 1-byte packets from both: strict alternation
    do_reset();
    for (int k = 0; k < 4; k++) begin
      qpush(0, 8'(8'h10 + k), 1'b1);
      qpush(1, 8'(8'h20 + k), 1'b1);
    end
    repeat (340) tick();
    chk("t3_count", 32'(pay_din.size()), 32'd8);
    c0 = 0;
    for (int k = 0; k < 8; k++) begin
      chk("t3_grant_alt", 32'(pg(k)), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (pg(k) == 2'b01) c0++;
    end
    chk("t3_req0_bytes", 32'(c0), 32'd4);

    // Req1 abandons its packet; grant revoked, pending req0 served next
    do_reset();
    qpush(1, 8'h44, 1'b0);
    repeat (5) tick();
    qpush(0, 8'h55, 1'b1);
    repeat (1120) tick();
    chk("t4_to_count", 32'(to_cyc.size()), 32'd1);
    chk("t4_to_delay", 32'(tc(0) - pc(0)), 32'd1040);
    chk("t4_first", 32'(pd(0)), 32'h44);
    chk("t4_next", 32'(pd(1)), 32'h55);
    chk("t4_next_grant", 32'(pg(1)), 32'd1);

    // uart busy long enough that a counting timeout would fire
    do_reset();
    uart_tx_busy = 1'b1;
    qpush(0, 8'h66, 1'b1);
    repeat (1100) tick();
    uart_tx_busy = 1'b0;
    b = cyc;
    repeat (40) tick();
    chk("t5_no_timeout", 32'(to_cyc.size()), 32'd0);
    chk("t5_no_ready", 32'(ready_while_busy), 32'd0);
    chk("t5_byte", 32'(pd(0)), 32'h66);
    chk("t5_accept", 32'(pc(0)), 32'(b + 1 + 17 * TAG_EN));

    // Reset in the middle of a packet
    do_reset();
    qpush(0, 8'h77, 1'b0); qpush(0, 8'h78, 1'b0); qpush(0, 8'h79, 1'b1);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_wr_en", 32'(uart_wr_en), 32'd0);
    chk("t6_din", 32'(uart_din), 32'd0);
    chk("t6_arb_busy", 32'(arb_busy), 32'd0);
    chk("t6_timeout", 32'(timeout_pulse), 32'd0);
    clear_logs();
    qpush(1, 8'h9A, 1'b1);
    qpush(0, 8'h9B, 1'b1);
    repeat (80) tick();
    chk("t6_first", 32'(pd(0)), 32'h9B);
    chk("t6_first_grant", 32'(pg(0)), 32'd1);
    chk("t6_second", 32'(pd(1)), 32'h9A);
    chk("t6_tag_count", 32'(tag_din.size()), 32'(2 * TAG_EN));
    for (int k = 0; k < tag_din.size(); k++)
      chk("t6_tag", 32'(tag_din[k]), (k == 0) ? 32'hA0 : 32'hA1);

    // Randomized traffic, busy and occasional reset
    do_reset();
    rnd_mode = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (qsize(r) == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) qpush(r, 8'($urandom), j == len - 1);
        end
      end
      uart_tx_busy = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; uart_tx_busy = 1'b0; rnd_mode = 1'b0;
    repeat (400) tick();
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
